// File: rtl/rv32_pkg.sv
// RV32I decode constants: opcodes, ALU op encoding, immediate formats and the packed control bundle.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC:            return IMM_U;
      OPC_JAL:                       return IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: return IMM_I;
      OPC_BRANCH:                    return IMM_B;
      OPC_STORE:                     return IMM_S;
      default:                       return IMM_R;
    endcase
  endfunction

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: I/S/B/U/J formats sign-extended to XLEN; R-type and unknown give 0.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  import rv32_pkg::*;

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: 1-cycle decode into ID/EX; load-use inserts one bubble and drops id_ready, ex_stall holds ID/EX.
// Flush beats stall. Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] reg_read_rs1,
  input  logic [XLEN-1:0] reg_read_rs2,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);
  import rv32_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    ctrl_t           ctrl;
  } idex_t;

  idex_t           idex_q, idex_d;
  ctrl_t           dec;
  logic            use_rs1, use_rs2, hazard;
  logic [XLEN-1:0] imm, op1, op2;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(if_instr), .imm(imm));

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.alu_op = ALU_PASSB; end
      OPC_AUIPC:  begin dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; end
      OPC_JAL:    begin dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.jump = 1'b1; end
      OPC_JALR:   begin dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.jump = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        // funct7[5] is immediate data except on the right-shift encoding
        dec.alu_op      = alu_from_funct(funct3, if_instr[30] && (funct3 == 3'b101));
        use_rs1         = 1'b1;
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_funct(funct3, if_instr[30]);
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      default:    dec.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign op1 = (rs1 == 5'd0) ? '0 :
               (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : reg_read_rs1;
  assign op2 = (rs2 == 5'd0) ? '0 :
               (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : reg_read_rs2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
  assign op1 = (rs1 == 5'd0) ? '0 : reg_read_rs1;
  assign op2 = (rs2 == 5'd0) ? '0 : reg_read_rs2;
`endif

  assign hazard = if_valid && idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) &&
                  ((use_rs1 && idex_q.rd == rs1) || (use_rs2 && idex_q.rd == rs2));

  assign id_ready = flush || (!ex_stall && !hazard);

  // An empty IF/ID slot loads as a bubble so ex_valid=0 always means all controls are 0
  always_comb begin
    idex_d = '0;
    if (if_valid) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = if_pc;
      idex_d.rs1_val = op1;
      idex_d.rs2_val = op2;
      idex_d.imm     = imm;
      idex_d.rd      = rd;
      idex_d.rs1     = rs1;
      idex_d.rs2     = rs2;
      idex_d.ctrl    = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         idex_q <= '0;
    else if (flush)    idex_q <= '0;
    else if (ex_stall) idex_q <= idex_q;
    else if (hazard)   idex_q <= '0;
    else               idex_q <= idex_d;
  end

  assign ex_valid       = idex_q.valid;
  assign ex_pc          = idex_q.pc;
  assign ex_rs1_val     = idex_q.rs1_val;
  assign ex_rs2_val     = idex_q.rs2_val;
  assign ex_imm         = idex_q.imm;
  assign ex_rd          = idex_q.rd;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_alu_op      = idex_q.ctrl.alu_op;
  assign ex_alu_src_imm = idex_q.ctrl.alu_src_imm;
  assign ex_mem_read    = idex_q.ctrl.mem_read;
  assign ex_mem_write   = idex_q.ctrl.mem_write;
  assign ex_reg_write   = idex_q.ctrl.reg_write;
  assign ex_branch      = idex_q.ctrl.branch;
  assign ex_jump        = idex_q.ctrl.jump;
  assign ex_illegal     = idex_q.ctrl.illegal;

endmodule
